// File: rtl/adder_pkg.sv
// Shared constants and types for the registered adder slice.
package adder_pkg;

    localparam int unsigned ADDER_DEFAULT_WIDTH = 4;
    localparam int unsigned ADDER_MAX_WIDTH     = 32;

    // Full {cout,sum} result at the widest legal WIDTH; narrower builds use the low sum bits.
    typedef struct packed {
        logic                       cout;
        logic [ADDER_MAX_WIDTH-1:0] sum;
    } adder_result_t;

endpackage

// File: rtl/adder_core_if.sv
// Operand/result bundle for adder_core; the ovf signal exists only when ADDER_OVF_EN is defined.
interface adder_core_if import adder_pkg::*; #(
    parameter int unsigned WIDTH = ADDER_DEFAULT_WIDTH
) ();

    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef ADDER_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid,
        output a,
        output b,
        output cin,
        input  out_valid,
        input  sum,
`ifdef ADDER_OVF_EN
        input  ovf,
`endif
        input  cout
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  cin,
        output out_valid,
        output sum,
`ifdef ADDER_OVF_EN
        output ovf,
`endif
        output cout
    );

endinterface

// File: rtl/adder_ripple.sv
// Purely combinational WIDTH-bit ripple-carry adder built from per-bit full adders.
module adder_ripple import adder_pkg::*; #(
    parameter int unsigned WIDTH = ADDER_DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] w_carry;

    assign w_carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic w_prop;
        assign w_prop         = a[i] ^ b[i];
        assign sum[i]         = w_prop ^ w_carry[i];
        assign w_carry[i + 1] = (a[i] & b[i]) | (w_prop & w_carry[i]);
    end

    assign cout = w_carry[WIDTH];

endmodule

// File: rtl/adder_core.sv
// Registered adder: captures on in_valid, presents {cout,sum} one cycle later.
// Optional signed-overflow flag enabled by defining ADDER_OVF_EN.
module adder_core import adder_pkg::*; #(
    parameter int unsigned WIDTH = ADDER_DEFAULT_WIDTH
) (
    input  logic       clk,
    input  logic       rst,
    adder_core_if.slave bus
);

    logic [WIDTH-1:0] w_sum;
    logic             w_cout;

    logic             r_valid;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    adder_ripple #(
        .WIDTH (WIDTH)
    ) u_ripple (
        .a    (bus.a),
        .b    (bus.b),
        .cin  (bus.cin),
        .sum  (w_sum),
        .cout (w_cout)
    );

    // Result registers only load on in_valid so idle (possibly X) operands never reach outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            r_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_sum  <= w_sum;
                r_cout <= w_cout;
            end
        end
    end

    assign bus.out_valid = r_valid;
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;

`ifdef ADDER_OVF_EN
    logic w_ovf;
    logic r_ovf;

    assign w_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (w_sum[WIDTH-1] != bus.a[WIDTH-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (bus.in_valid) begin
            r_ovf <= w_ovf;
        end
    end

    assign bus.ovf = r_ovf;
`endif

endmodule

// File: tb/tb_adder_core.sv
// Directed self-checking bench for adder_core (WIDTH=4); ovf checks follow ADDER_OVF_EN.
module tb_adder_core;
    import adder_pkg::*;

    localparam int unsigned W = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    adder_core_if #(.WIDTH(W)) bus_if ();

    adder_core #(
        .WIDTH (W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs at the falling edge, then wait past the next rising edge to sample.
    task automatic drive(input logic v, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic cv);
        @(negedge clk);
        bus_if.in_valid = v;
        bus_if.a        = av;
        bus_if.b        = bv;
        bus_if.cin      = cv;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        // 9+9+1 = 19 -> sum 3, cout 1, signed -7+-7+1 overflows
        drive(1'b1, 4'd9, 4'd9, 1'b1);
        checks++;
        if (bus_if.sum !== 4'd3 || bus_if.cout !== 1'b1 || bus_if.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: got sum=%b cout=%b v=%b, want sum=0011 cout=1 v=1",
                     bus_if.sum, bus_if.cout, bus_if.out_valid);
        end
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus_if.sum !== 4'd0 || bus_if.cout !== 1'b0 || bus_if.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got sum=%b cout=%b v=%b, want all zero",
                     bus_if.sum, bus_if.cout, bus_if.out_valid);
        end
`ifdef ADDER_OVF_EN
        checks++;
        if (bus_if.ovf !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_ovf: got %b, want 0", bus_if.ovf);
        end
`endif
        @(posedge clk);
        #1;
        checks++;
        if (bus_if.sum !== 4'd0 || bus_if.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: got sum=%b v=%b, want sum=0000 v=0",
                     bus_if.sum, bus_if.out_valid);
        end
        @(negedge clk);
        rst             = 1'b0;
        bus_if.in_valid = 1'b0;
    endtask

    task automatic test_basic;
        drive(1'b1, 4'b0011, 4'b0011, 1'b0);
        checks++;
        if (bus_if.sum !== 4'b0110 || bus_if.cout !== 1'b0 || bus_if.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL basic_3p3: got sum=%b cout=%b v=%b, want sum=0110 cout=0 v=1",
                     bus_if.sum, bus_if.cout, bus_if.out_valid);
        end
`ifdef ADDER_OVF_EN
        checks++;
        if (bus_if.ovf !== 1'b0) begin
            errors++;
            $display("FAIL basic_3p3_ovf: got %b, want 0", bus_if.ovf);
        end
`endif
    endtask

    task automatic test_wrap;
        drive(1'b1, 4'b1011, 4'b0111, 1'b1);
        checks++;
        if (bus_if.sum !== 4'b0011 || bus_if.cout !== 1'b1 || bus_if.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL wrap: got sum=%b cout=%b v=%b, want sum=0011 cout=1 v=1",
                     bus_if.sum, bus_if.cout, bus_if.out_valid);
        end
`ifdef ADDER_OVF_EN
        checks++;
        if (bus_if.ovf !== 1'b0) begin
            errors++;
            $display("FAIL wrap_ovf: got %b, want 0", bus_if.ovf);
        end
`endif
    endtask

    task automatic test_max;
        drive(1'b1, 4'b1111, 4'b1111, 1'b1);
        checks++;
        if (bus_if.sum !== 4'b1111 || bus_if.cout !== 1'b1 || bus_if.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL max: got sum=%b cout=%b v=%b, want sum=1111 cout=1 v=1",
                     bus_if.sum, bus_if.cout, bus_if.out_valid);
        end
    endtask

    task automatic test_ovf;
        drive(1'b1, 4'b0111, 4'b0001, 1'b0);
        checks++;
        if (bus_if.sum !== 4'b1000 || bus_if.cout !== 1'b0) begin
            errors++;
            $display("FAIL ovf_case: got sum=%b cout=%b, want sum=1000 cout=0",
                     bus_if.sum, bus_if.cout);
        end
`ifdef ADDER_OVF_EN
        checks++;
        if (bus_if.ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_flag: got %b, want 1", bus_if.ovf);
        end
`endif
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] va [3];
        logic [W-1:0] vb [3];
        logic         vc [3];
        logic [W-1:0] es [3];
        logic         ec [3];
        logic         eo [3];
        va = '{4'd2, 4'd8, 4'd6};
        vb = '{4'd3, 4'd8, 4'd5};
        vc = '{1'b0, 1'b0, 1'b1};
        es = '{4'b0101, 4'b0000, 4'b1100};
        ec = '{1'b0, 1'b1, 1'b0};
        eo = '{1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, va[i], vb[i], vc[i]);
            checks++;
            if (bus_if.out_valid !== 1'b1 || bus_if.sum !== es[i] || bus_if.cout !== ec[i]) begin
                errors++;
                $display("FAIL b2b_%0d: got sum=%b cout=%b v=%b, want sum=%b cout=%b v=1",
                         i, bus_if.sum, bus_if.cout, bus_if.out_valid, es[i], ec[i]);
            end
`ifdef ADDER_OVF_EN
            checks++;
            if (bus_if.ovf !== eo[i]) begin
                errors++;
                $display("FAIL b2b_ovf_%0d: got %b, want %b", i, bus_if.ovf, eo[i]);
            end
`else
            if (eo[i] === 1'bx) $display("unexpected X in table");
`endif
        end
        // Idle with X operands: outputs must hold the last result
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 'x, 'x, 1'bx);
            checks++;
            if (bus_if.out_valid !== 1'b0 || bus_if.sum !== 4'b1100 || bus_if.cout !== 1'b0) begin
                errors++;
                $display("FAIL idle_hold_%0d: got sum=%b cout=%b v=%b, want sum=1100 cout=0 v=0",
                         i, bus_if.sum, bus_if.cout, bus_if.out_valid);
            end
`ifdef ADDER_OVF_EN
            checks++;
            if (bus_if.ovf !== 1'b1) begin
                errors++;
                $display("FAIL idle_hold_ovf_%0d: got %b, want 1", i, bus_if.ovf);
            end
`endif
        end
    endtask

    task automatic test_reset_mid;
        drive(1'b1, 4'd1, 4'd1, 1'b0);
        @(negedge clk);
        bus_if.in_valid = 1'b1;
        bus_if.a        = 4'd5;
        bus_if.b        = 4'd6;
        bus_if.cin      = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus_if.sum !== 4'd0 || bus_if.cout !== 1'b0 || bus_if.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got sum=%b cout=%b v=%b, want all zero",
                     bus_if.sum, bus_if.cout, bus_if.out_valid);
        end
        // Release with in_valid low: nothing in flight may emerge
        @(negedge clk);
        rst = 1'b0;
        bus_if.in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus_if.out_valid !== 1'b0 || bus_if.sum !== 4'd0) begin
            errors++;
            $display("FAIL post_reset_idle: got sum=%b v=%b, want sum=0000 v=0",
                     bus_if.sum, bus_if.out_valid);
        end
        // Release with in_valid high: first edge produces a result
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 4'd3, 4'd4, 1'b0);
        checks++;
        if (bus_if.out_valid !== 1'b1 || bus_if.sum !== 4'd7 || bus_if.cout !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_valid: got sum=%b cout=%b v=%b, want sum=0111 cout=0 v=1",
                     bus_if.sum, bus_if.cout, bus_if.out_valid);
        end
        bus_if.in_valid = 1'b0;
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        rst             = 1'b0;
        bus_if.in_valid = 1'b0;
        bus_if.a        = '0;
        bus_if.b        = '0;
        bus_if.cin      = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
        test_max();
        test_ovf();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
